// File: rtl/wts_adsr_pkg.sv
// Shared types and constants for the 5-channel WTS ADSR envelope generator.
package wts_adsr_pkg;

   localparam int unsigned NUM_CH = 5;
   localparam logic [6:0] ENV_MAX = 7'd64;

   typedef enum logic [2:0] {
      StIdle,
      StAttack,
      StDecay,
      StSustain,
      StRelease
   } adsr_state_t;

endpackage

// File: rtl/wts_adsr_env_step.sv
// Combinational next-state of one envelope channel; shared by whichever slot is active.
module wts_adsr_env_step
   import wts_adsr_pkg::*;
(
   input  adsr_state_t state_i,
   input  logic [6:0]  level_i,
   input  logic [7:0]  cnt_i,
   input  logic [7:0]  ar_i,
   input  logic [7:0]  dr_i,
   input  logic [7:0]  sr_i,
   input  logic [7:0]  rr_i,
   input  logic [5:0]  sl_i,
   input  logic        key_on_i,
   input  logic        key_release_i,
   input  logic        key_off_i,
   output adsr_state_t state_o,
   output logic [6:0]  level_o,
   output logic [7:0]  cnt_o
);

   logic [7:0] rate;
   logic       rate_hit;

   always_comb begin
      case (state_i)
         StAttack:  rate = ar_i;
         StDecay:   rate = dr_i;
         StSustain: rate = sr_i;
         StRelease: rate = rr_i;
         default:   rate = 8'd0;
      endcase
   end

   assign rate_hit = (rate != 8'd0) && (cnt_i == rate - 8'd1);

   always_comb begin
      state_o = state_i;
      level_o = level_i;
      cnt_o   = cnt_i;
      if (key_off_i) begin
         state_o = StIdle;
         level_o = 7'd0;
         cnt_o   = 8'd0;
      end else if (key_on_i) begin
         // retrigger keeps the current level
         cnt_o   = 8'd0;
         state_o = StAttack;
         if (ar_i == 8'd0) begin
            level_o = ENV_MAX;
            state_o = StDecay;
         end
      end else if (key_release_i && state_i != StIdle) begin
         state_o = StRelease;
         cnt_o   = 8'd0;
      end else begin
         if (rate != 8'd0) cnt_o = rate_hit ? 8'd0 : cnt_i + 8'd1;
         case (state_i)
            StAttack: begin
               if (ar_i == 8'd0 || level_i >= ENV_MAX) begin
                  level_o = ENV_MAX;
                  state_o = StDecay;
                  cnt_o   = 8'd0;
               end else if (rate_hit) begin
                  level_o = level_i + 7'd1;
                  if (level_i + 7'd1 == ENV_MAX) state_o = StDecay;
               end
            end
            StDecay: begin
               if (level_i <= {1'b0, sl_i}) begin
                  state_o = StSustain;
                  cnt_o   = 8'd0;
               end else if (rate_hit) begin
                  level_o = level_i - 7'd1;
               end
            end
            StSustain: begin
               if (rate_hit && level_i != 7'd0) level_o = level_i - 7'd1;
            end
            StRelease: begin
               if (level_i == 7'd0) begin
                  state_o = StIdle;
                  cnt_o   = 8'd0;
               end else if (rate_hit) begin
                  level_o = level_i - 7'd1;
                  if (level_i == 7'd1) state_o = StIdle;
               end
            end
            default: cnt_o = 8'd0;
         endcase
      end
   end

endmodule

// File: rtl/wts_adsr_envelope_generator_5ch.sv
// Five ADSR envelopes updated time-multiplexed by 'active'; envelope shows the selected level.
module wts_adsr_envelope_generator_5ch
   import wts_adsr_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  active,
   output logic [6:0]  envelope,
   input  logic        ch_a_key_on,
   input  logic        ch_a_key_release,
   input  logic        ch_a_key_off,
   input  logic        ch_b_key_on,
   input  logic        ch_b_key_release,
   input  logic        ch_b_key_off,
   input  logic        ch_c_key_on,
   input  logic        ch_c_key_release,
   input  logic        ch_c_key_off,
   input  logic        ch_d_key_on,
   input  logic        ch_d_key_release,
   input  logic        ch_d_key_off,
   input  logic        ch_e_key_on,
   input  logic        ch_e_key_release,
   input  logic        ch_e_key_off,
   input  logic [7:0]  reg_ar_a, reg_ar_b, reg_ar_c, reg_ar_d, reg_ar_e,
   input  logic [7:0]  reg_dr_a, reg_dr_b, reg_dr_c, reg_dr_d, reg_dr_e,
   input  logic [7:0]  reg_sr_a, reg_sr_b, reg_sr_c, reg_sr_d, reg_sr_e,
   input  logic [7:0]  reg_rr_a, reg_rr_b, reg_rr_c, reg_rr_d, reg_rr_e,
   input  logic [5:0]  reg_sl_a, reg_sl_b, reg_sl_c, reg_sl_d, reg_sl_e,
   input  logic [1:0]  reg_wave_length_a, reg_wave_length_b, reg_wave_length_c,
   input  logic [1:0]  reg_wave_length_d, reg_wave_length_e,
   input  logic [11:0] reg_frequency_count_a, reg_frequency_count_b, reg_frequency_count_c,
   input  logic [11:0] reg_frequency_count_d, reg_frequency_count_e
);

   logic [NUM_CH-1:0] key_on, key_release, key_off;
   logic [NUM_CH-1:0] ev_on, ev_release, ev_off;
   logic [NUM_CH-1:0] pend_on_q, pend_release_q, pend_off_q;
   logic [NUM_CH-1:0] pend_on_d, pend_release_d, pend_off_d;
   logic [NUM_CH-1:0] slot_hit;
   logic [7:0]        ar [NUM_CH];
   logic [7:0]        dr [NUM_CH];
   logic [7:0]        sr [NUM_CH];
   logic [7:0]        rr [NUM_CH];
   logic [5:0]        sl [NUM_CH];

   adsr_state_t       state_q [NUM_CH];
   logic [6:0]        level_q [NUM_CH];
   logic [7:0]        cnt_q   [NUM_CH];

   logic              slot_valid;
   logic [2:0]        sel;
   adsr_state_t       step_state;
   logic [6:0]        step_level;
   logic [7:0]        step_cnt;
   logic              unused_key_scale;

   assign key_on      = {ch_e_key_on, ch_d_key_on, ch_c_key_on, ch_b_key_on, ch_a_key_on};
   assign key_release = {ch_e_key_release, ch_d_key_release, ch_c_key_release,
                         ch_b_key_release, ch_a_key_release};
   assign key_off     = {ch_e_key_off, ch_d_key_off, ch_c_key_off, ch_b_key_off, ch_a_key_off};

   assign ar = '{reg_ar_a, reg_ar_b, reg_ar_c, reg_ar_d, reg_ar_e};
   assign dr = '{reg_dr_a, reg_dr_b, reg_dr_c, reg_dr_d, reg_dr_e};
   assign sr = '{reg_sr_a, reg_sr_b, reg_sr_c, reg_sr_d, reg_sr_e};
   assign rr = '{reg_rr_a, reg_rr_b, reg_rr_c, reg_rr_d, reg_rr_e};
   assign sl = '{reg_sl_a, reg_sl_b, reg_sl_c, reg_sl_d, reg_sl_e};

   // Key scaling inputs are reserved and intentionally unused.
   assign unused_key_scale = ^{reg_wave_length_a, reg_wave_length_b, reg_wave_length_c,
                               reg_wave_length_d, reg_wave_length_e,
                               reg_frequency_count_a, reg_frequency_count_b,
                               reg_frequency_count_c, reg_frequency_count_d,
                               reg_frequency_count_e};

   assign slot_valid = (active < 3'(NUM_CH));
   assign sel        = slot_valid ? active : 3'd0;

   always_comb begin
      slot_hit = '0;
      if (slot_valid) slot_hit[sel] = 1'b1;
   end

   // A live pulse and a held pending flag are equivalent; the owning slot consumes both.
   assign ev_on          = key_on | pend_on_q;
   assign ev_release     = key_release | pend_release_q;
   assign ev_off         = key_off | pend_off_q;
   assign pend_on_d      = ev_on & ~slot_hit;
   assign pend_release_d = ev_release & ~slot_hit;
   assign pend_off_d     = ev_off & ~slot_hit;

   wts_adsr_env_step u_step (
      .state_i       (state_q[sel]),
      .level_i       (level_q[sel]),
      .cnt_i         (cnt_q[sel]),
      .ar_i          (ar[sel]),
      .dr_i          (dr[sel]),
      .sr_i          (sr[sel]),
      .rr_i          (rr[sel]),
      .sl_i          (sl[sel]),
      .key_on_i      (ev_on[sel]),
      .key_release_i (ev_release[sel]),
      .key_off_i     (ev_off[sel]),
      .state_o       (step_state),
      .level_o       (step_level),
      .cnt_o         (step_cnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_on_q      <= '0;
         pend_release_q <= '0;
         pend_off_q     <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= StIdle;
            level_q[i] <= 7'd0;
            cnt_q[i]   <= 8'd0;
         end
      end else begin
         pend_on_q      <= pend_on_d;
         pend_release_q <= pend_release_d;
         pend_off_q     <= pend_off_d;
         if (slot_valid) begin
            state_q[sel] <= step_state;
            level_q[sel] <= step_level;
            cnt_q[sel]   <= step_cnt;
         end
      end
   end

   assign envelope = slot_valid ? level_q[sel] : 7'd0;

endmodule

// File: tb/tb_wts_adsr_envelope_generator_5ch.sv
// Scoreboard bench for the 5-channel ADSR envelope generator.
module tb_wts_adsr_envelope_generator_5ch;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  active;
   logic [6:0]  envelope;
   logic        ch_a_key_on, ch_a_key_release, ch_a_key_off;
   logic        ch_b_key_on, ch_b_key_release, ch_b_key_off;
   logic        ch_c_key_on, ch_c_key_release, ch_c_key_off;
   logic        ch_d_key_on, ch_d_key_release, ch_d_key_off;
   logic        ch_e_key_on, ch_e_key_release, ch_e_key_off;
   logic [7:0]  reg_ar_a, reg_ar_b, reg_ar_c, reg_ar_d, reg_ar_e;
   logic [7:0]  reg_dr_a, reg_dr_b, reg_dr_c, reg_dr_d, reg_dr_e;
   logic [7:0]  reg_sr_a, reg_sr_b, reg_sr_c, reg_sr_d, reg_sr_e;
   logic [7:0]  reg_rr_a, reg_rr_b, reg_rr_c, reg_rr_d, reg_rr_e;
   logic [5:0]  reg_sl_a, reg_sl_b, reg_sl_c, reg_sl_d, reg_sl_e;
   logic [1:0]  reg_wl;
   logic [11:0] reg_fc;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [6:0]  sb [$];

   always #5 clk = ~clk;

   wts_adsr_envelope_generator_5ch dut (
      .clk(clk), .reset(reset), .active(active), .envelope(envelope),
      .ch_a_key_on(ch_a_key_on), .ch_a_key_release(ch_a_key_release), .ch_a_key_off(ch_a_key_off),
      .ch_b_key_on(ch_b_key_on), .ch_b_key_release(ch_b_key_release), .ch_b_key_off(ch_b_key_off),
      .ch_c_key_on(ch_c_key_on), .ch_c_key_release(ch_c_key_release), .ch_c_key_off(ch_c_key_off),
      .ch_d_key_on(ch_d_key_on), .ch_d_key_release(ch_d_key_release), .ch_d_key_off(ch_d_key_off),
      .ch_e_key_on(ch_e_key_on), .ch_e_key_release(ch_e_key_release), .ch_e_key_off(ch_e_key_off),
      .reg_ar_a(reg_ar_a), .reg_ar_b(reg_ar_b), .reg_ar_c(reg_ar_c), .reg_ar_d(reg_ar_d),
      .reg_ar_e(reg_ar_e),
      .reg_dr_a(reg_dr_a), .reg_dr_b(reg_dr_b), .reg_dr_c(reg_dr_c), .reg_dr_d(reg_dr_d),
      .reg_dr_e(reg_dr_e),
      .reg_sr_a(reg_sr_a), .reg_sr_b(reg_sr_b), .reg_sr_c(reg_sr_c), .reg_sr_d(reg_sr_d),
      .reg_sr_e(reg_sr_e),
      .reg_rr_a(reg_rr_a), .reg_rr_b(reg_rr_b), .reg_rr_c(reg_rr_c), .reg_rr_d(reg_rr_d),
      .reg_rr_e(reg_rr_e),
      .reg_sl_a(reg_sl_a), .reg_sl_b(reg_sl_b), .reg_sl_c(reg_sl_c), .reg_sl_d(reg_sl_d),
      .reg_sl_e(reg_sl_e),
      .reg_wave_length_a(reg_wl), .reg_wave_length_b(reg_wl), .reg_wave_length_c(reg_wl),
      .reg_wave_length_d(reg_wl), .reg_wave_length_e(reg_wl),
      .reg_frequency_count_a(reg_fc), .reg_frequency_count_b(reg_fc),
      .reg_frequency_count_c(reg_fc), .reg_frequency_count_d(reg_fc),
      .reg_frequency_count_e(reg_fc)
   );

   task automatic test_reset();
      logic [6:0] e;
      reset = 1'b1;
      active = 3'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 50; k++) sb.push_back(7'd0);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL reset k=%0d envelope=%0d expected=%0d", k, envelope, e);
         end
      end
   endtask

   // AR=0 jumps to 64; RR=0 release holds; key_off silences.
   task automatic test_instant_hold_off();
      logic [6:0] e;
      for (int k = 0; k < 50; k++) sb.push_back(7'd64);
      ch_a_key_on = 1'b1;
      @(negedge clk);
      ch_a_key_on = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (k != 0) @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL instant_attack k=%0d envelope=%0d expected=%0d", k, envelope, e);
         end
      end
      for (int k = 0; k < 50; k++) sb.push_back(7'd64);
      @(negedge clk);
      ch_a_key_release = 1'b1;
      @(negedge clk);
      ch_a_key_release = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (k != 0) @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL release_hold k=%0d envelope=%0d expected=%0d", k, envelope, e);
         end
      end
      for (int k = 0; k < 50; k++) sb.push_back(7'd0);
      @(negedge clk);
      ch_a_key_off = 1'b1;
      @(negedge clk);
      ch_a_key_off = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (k != 0) @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL key_off k=%0d envelope=%0d expected=%0d", k, envelope, e);
         end
      end
   endtask

   // Full attack/decay/sustain, then release to zero.
   task automatic test_adsr_cycle();
      logic [6:0] e;
      int lvl;
      reg_ar_a = 8'd2; reg_dr_a = 8'd3; reg_sl_a = 6'd60; reg_sr_a = 8'd100; reg_rr_a = 8'd4;
      for (int k = 0; k <= 360; k++) begin
         if (k <= 128)      lvl = k / 2;
         else if (k <= 140) lvl = 64 - (k - 128) / 3;
         else               lvl = 60 - (k - 141) / 100;
         sb.push_back(7'(lvl));
      end
      @(negedge clk);
      ch_a_key_on = 1'b1;
      @(negedge clk);
      ch_a_key_on = 1'b0;
      for (int k = 0; k <= 360; k++) begin
         if (k != 0) @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL adsr k=%0d envelope=%0d expected=%0d", k, envelope, e);
         end
      end
      for (int r = 0; r <= 245; r++) begin
         lvl = (r / 4 >= 58) ? 0 : 58 - r / 4;
         sb.push_back(7'(lvl));
      end
      ch_a_key_release = 1'b1;
      @(negedge clk);
      ch_a_key_release = 1'b0;
      for (int r = 0; r <= 245; r++) begin
         if (r != 0) @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL adsr_release r=%0d envelope=%0d expected=%0d", r, envelope, e);
         end
      end
   endtask

   task automatic test_decay_to_zero();
      logic [6:0] e;
      int lvl;
      reg_ar_a = 8'd0; reg_dr_a = 8'd3; reg_sl_a = 6'd0; reg_sr_a = 8'd0; reg_rr_a = 8'd3;
      for (int k = 0; k <= 200; k++) begin
         lvl = (k / 3 >= 64) ? 0 : 64 - k / 3;
         sb.push_back(7'(lvl));
      end
      for (int k = 0; k < 10; k++) sb.push_back(7'd0);
      @(negedge clk);
      ch_a_key_on = 1'b1;
      @(negedge clk);
      ch_a_key_on = 1'b0;
      for (int k = 0; k <= 200; k++) begin
         if (k != 0) @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL decay_zero k=%0d envelope=%0d expected=%0d", k, envelope, e);
         end
      end
      ch_a_key_release = 1'b1;
      @(negedge clk);
      ch_a_key_release = 1'b0;
      for (int r = 0; r < 10; r++) begin
         if (r != 0) @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL release_at_zero r=%0d envelope=%0d expected=%0d", r, envelope, e);
         end
      end
   endtask

   // Key-on mid-release climbs from the current level instead of restarting at 0.
   task automatic test_retrigger();
      logic [6:0] e;
      int lvl;
      reg_ar_a = 8'd0; reg_dr_a = 8'd0; reg_sl_a = 6'd0; reg_rr_a = 8'd1;
      for (int k = 0; k < 5; k++) sb.push_back(7'd64);
      for (int r = 0; r <= 10; r++) sb.push_back(7'(64 - r));
      for (int j = 0; j <= 20; j++) begin
         lvl = (54 + j > 64) ? 64 : 54 + j;
         sb.push_back(7'(lvl));
      end
      @(negedge clk);
      ch_a_key_on = 1'b1;
      @(negedge clk);
      ch_a_key_on = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k != 0) @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL retrig_on k=%0d envelope=%0d expected=%0d", k, envelope, e);
         end
      end
      @(negedge clk);
      ch_a_key_release = 1'b1;
      @(negedge clk);
      ch_a_key_release = 1'b0;
      for (int r = 0; r <= 10; r++) begin
         if (r != 0) @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL retrig_release r=%0d envelope=%0d expected=%0d", r, envelope, e);
         end
      end
      reg_ar_a = 8'd1;
      ch_a_key_on = 1'b1;
      @(negedge clk);
      ch_a_key_on = 1'b0;
      for (int j = 0; j <= 20; j++) begin
         if (j != 0) @(negedge clk);
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL retrig_attack j=%0d envelope=%0d expected=%0d", j, envelope, e);
         end
      end
   endtask

   // Pending keys, idle slots, key_off priority, and reset regardless of slot.
   task automatic test_slots();
      logic [6:0] e;
      logic [6:0] exp_list [13];
      string      tags [13];
      int         idx;
      exp_list = '{7'd64, 7'd0, 7'd64, 7'd0, 7'd64, 7'd0, 7'd0, 7'd0, 7'd64, 7'd0, 7'd0,
                   7'd0, 7'd0};
      tags = '{"slot_a_kept", "slot_b_pending", "slot_b_consumed", "slot_idle",
               "slot_c_on", "on_off_same", "on_off_hold", "on_off_hold2",
               "slot_b_before_off", "slot_b_pending_off", "reset_mid_a", "reset_mid_b",
               "reset_mid_c"};
      foreach (exp_list[i]) sb.push_back(exp_list[i]);
      idx = 0;
      reg_ar_b = 8'd0; reg_ar_c = 8'd0;
      @(negedge clk);
      active = 3'd0;
      ch_b_key_on = 1'b1;
      @(negedge clk);
      ch_b_key_on = 1'b0;
      for (int step = 0; step < 13; step++) begin
         case (step)
            1:  begin active = 3'd1; #1; end
            2:  @(negedge clk);
            3:  begin active = 3'd5; #1; end
            4:  begin
                   active = 3'd2; ch_c_key_on = 1'b1;
                   @(negedge clk);
                   ch_c_key_on = 1'b0;
                end
            5:  begin
                   ch_c_key_on = 1'b1; ch_c_key_off = 1'b1;
                   @(negedge clk);
                   ch_c_key_on = 1'b0; ch_c_key_off = 1'b0;
                end
            6, 7: @(negedge clk);
            8:  begin
                   ch_b_key_off = 1'b1;
                   @(negedge clk);
                   ch_b_key_off = 1'b0;
                   active = 3'd1; #1;
                end
            9:  @(negedge clk);
            10: begin
                   active = 3'd5; reset = 1'b1;
                   @(negedge clk);
                   reset = 1'b0; active = 3'd0; #1;
                end
            11: begin active = 3'd1; #1; end
            12: begin active = 3'd2; #1; end
            default: ;
         endcase
         e = sb.pop_front();
         n_checks++;
         if (envelope !== e) begin
            n_fail++;
            $display("FAIL %s envelope=%0d expected=%0d", tags[idx], envelope, e);
         end
         idx++;
      end
   endtask

   initial begin
      reset = 1'b1; active = 3'd0;
      {ch_a_key_on, ch_a_key_release, ch_a_key_off} = '0;
      {ch_b_key_on, ch_b_key_release, ch_b_key_off} = '0;
      {ch_c_key_on, ch_c_key_release, ch_c_key_off} = '0;
      {ch_d_key_on, ch_d_key_release, ch_d_key_off} = '0;
      {ch_e_key_on, ch_e_key_release, ch_e_key_off} = '0;
      {reg_ar_a, reg_ar_b, reg_ar_c, reg_ar_d, reg_ar_e} = '0;
      {reg_dr_a, reg_dr_b, reg_dr_c, reg_dr_d, reg_dr_e} = '0;
      {reg_sr_a, reg_sr_b, reg_sr_c, reg_sr_d, reg_sr_e} = '0;
      {reg_rr_a, reg_rr_b, reg_rr_c, reg_rr_d, reg_rr_e} = '0;
      {reg_sl_a, reg_sl_b, reg_sl_c, reg_sl_d, reg_sl_e} = '0;
      reg_wl = 2'd3;
      reg_fc = 12'hA5A;
      test_reset();
      test_instant_hold_off();
      test_adsr_cycle();
      test_decay_to_zero();
      test_retrigger();
      test_slots();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
